// File: rtl/object_buffer_reader.sv
// Row buffer for TABLE_ENTRY objects: writes fill the lowest free row, reads retire into a
// registered valid/ready output stage. Define OBJECT_BUFFER_READER_AGE_ORDER_EN to retire in write order.
module object_buffer_reader #(
  parameter int unsigned ROWS   = 64,
  parameter int unsigned EntryW = 32,
  localparam int unsigned IdxW  = $clog2(ROWS),
  localparam int unsigned CntW  = $clog2(ROWS) + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [EntryW-1:0] i_new_entry,
  input  logic              i_valid_in,
  output logic              o_full,
  output logic              o_empty,
  output logic [CntW-1:0]   o_count,
  output logic [EntryW-1:0] o_out_entry,
  output logic [IdxW-1:0]   o_out_row,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  logic [ROWS-1:0]   r_valid;
  logic [EntryW-1:0] r_mem [ROWS];
  logic [CntW-1:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic [EntryW-1:0] r_out_entry;
  logic [IdxW-1:0]   r_out_row;
  logic              r_out_valid;

  logic [CntW-1:0]   w_count_next;
  logic [IdxW-1:0]   w_free;
  logic [IdxW-1:0]   w_rd_row;
  logic              w_write;
  logic              w_load;

  assign w_write = i_valid_in && !r_full;
  assign w_load  = (!r_out_valid || i_out_ready) && !r_empty;

  // Descending scan so the last hit is the lowest free row.
  always_comb begin
    w_free = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_free = IdxW'(i);
    end
  end

`ifdef OBJECT_BUFFER_READER_AGE_ORDER_EN
  logic [IdxW-1:0] r_order [ROWS];
  logic [IdxW-1:0] r_head;
  logic [IdxW-1:0] r_tail;

  assign w_rd_row = r_order[r_head];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_write) r_tail <= r_tail + IdxW'(1);
      if (w_load)  r_head <= r_head + IdxW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write) r_order[r_tail] <= w_free;
  end
`else
  always_comb begin
    w_rd_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (r_valid[i]) w_rd_row = IdxW'(i);
    end
  end
`endif

  // w_free is never valid and w_rd_row is always valid, so both updates can land together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else begin
      if (w_write) r_valid[w_free]   <= 1'b1;
      if (w_load)  r_valid[w_rd_row] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_write) r_mem[w_free] <= i_new_entry;
  end

  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_load) begin
      w_count_next = r_count + CntW'(1);
    end else if (!w_write && w_load) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next == CntW'(ROWS));
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_entry <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_row   <= w_rd_row;
      r_out_entry <= r_mem[w_rd_row];
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_count     = r_count;
  assign o_out_entry = r_out_entry;
  assign o_out_row   = r_out_row;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_object_buffer_reader.sv
// Randomized and directed bench for object_buffer_reader; a row/queue model feeds a scoreboard
// of expected output-stage contents that a negedge monitor checks.
module tb_object_buffer_reader;
  localparam int unsigned ROWS = 64;
  localparam int unsigned EW   = 32;
  localparam int unsigned IW   = 6;
  localparam int unsigned CW   = 7;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          valid_in  = 1'b0;
  logic          out_ready = 1'b0;
  logic [EW-1:0] new_entry = '0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [EW-1:0] out_entry;
  logic [IW-1:0] out_row;
  logic          out_valid;

  always #5 clk = ~clk;

  object_buffer_reader #(
    .ROWS   (ROWS),
    .EntryW (EW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_new_entry (new_entry),
    .i_valid_in  (valid_in),
    .o_full      (full),
    .o_empty     (empty),
    .o_count     (count),
    .o_out_entry (out_entry),
    .o_out_row   (out_row),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  typedef struct {
    logic [EW-1:0] e;
    int            r;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  // Model: row occupancy, payloads, write-order list of rows, output-stage flag.
  bit            mv [ROWS];
  logic [EW-1:0] md [ROWS];
  int            age_q[$];
  bit            m_out_valid = 1'b0;
  exp_t          exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model: compare state after each edge, then advance the model with the
  // inputs that the next edge will sample.
  initial begin
    foreach (mv[i]) mv[i] = 1'b0;
    forever begin
      int cnt;
      int free_row;
      int rd_row;
      bit wr;
      bit ld;
      bit hs;
      @(negedge clk);
      cnt = 0;
      foreach (mv[i]) cnt += int'(mv[i]);
      chk("count", 64'(count), 64'(cnt));
      chk("full", 64'(full), 64'(cnt == ROWS));
      chk("empty", 64'(empty), 64'(cnt == 0));
      chk("out_valid", 64'(out_valid), 64'(m_out_valid));
      if (out_valid && m_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: output presented with no expected entry at %0t", $time);
        end else begin
          chk("out_entry", 64'(out_entry), 64'(exp_q[0].e));
          chk("out_row", 64'(out_row), 64'(exp_q[0].r));
        end
      end
      if (reset) begin
        foreach (mv[i]) mv[i] = 1'b0;
        age_q.delete();
        exp_q.delete();
        m_out_valid = 1'b0;
      end else begin
        hs = m_out_valid && out_ready;
        if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
        wr = valid_in && (cnt < ROWS);
        ld = (!m_out_valid || out_ready) && (cnt > 0);
        free_row = -1;
        rd_row   = -1;
        for (int i = ROWS - 1; i >= 0; i--) begin
          if (!mv[i]) free_row = i;
          if (mv[i])  rd_row   = i;
        end
`ifdef OBJECT_BUFFER_READER_AGE_ORDER_EN
        if (age_q.size() > 0) rd_row = age_q[0];
`endif
        if (ld) begin
          exp_q.push_back('{e: md[rd_row], r: rd_row});
          mv[rd_row] = 1'b0;
          if (age_q.size() > 0) void'(age_q.pop_front());
          m_out_valid = 1'b1;
        end else if (hs) begin
          m_out_valid = 1'b0;
        end
        if (wr) begin
          mv[free_row] = 1'b1;
          md[free_row] = new_entry;
          age_q.push_back(free_row);
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit r, input logic [EW-1:0] e);
    valid_in  = v;
    out_ready = r;
    new_entry = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, r, '0);
  endtask

  bit saw_full = 1'b0;
  always @(negedge clk) if (full) saw_full <= 1'b1;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single write, first-output latency, drain back to empty.
    cyc(1'b1, 1'b1, 32'hA000_0001);
    idle(5, 1'b1);

    // Fill with the consumer stalled, including writes that must be dropped.
    for (int i = 0; i < 67; i++) cyc(1'b1, 1'b0, 32'hF000_0000 + 32'(i));
    // One retire from full, then a write into the freed row.
    cyc(1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 32'hB000_000B);
    cyc(1'b1, 1'b0, 32'hB000_000C);
    // Long stall then a single handshake.
    idle(5, 1'b0);
    cyc(1'b0, 1'b1, '0);
    idle(4, 1'b0);
    idle(80, 1'b1);

    // Retire ordering with a refilled low row.
    cyc(1'b1, 1'b0, 32'h0000_000A);
    cyc(1'b1, 1'b0, 32'h0000_000B);
    cyc(1'b1, 1'b0, 32'h0000_000C);
    cyc(1'b1, 1'b0, 32'h0000_000D);
    cyc(1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 32'h0000_000E);
    idle(10, 1'b1);

    // Reset mid-stream with entries buffered and the output stage held.
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 32'hC000_0000 + 32'(i));
    reset = 1'b1;
    cyc(1'b0, 1'b1, '0);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 32'hD000_0001);
    idle(4, 1'b1);

    // Random traffic with shifting write/read bias and rare resets.
    for (int seg = 0; seg < 8; seg++) begin
      int pw;
      int pr;
      pw = 20 + 10 * int'($urandom_range(0, 7));
      pr = 20 + 10 * int'($urandom_range(0, 7));
      for (int i = 0; i < 300; i++) begin
        reset = ($urandom_range(0, 599) == 0);
        cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), $urandom);
        reset = 1'b0;
      end
    end

    idle(ROWS + 10, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("full_reached", 64'(saw_full), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
